// File: rtl/weapon_controller.sv
// weapon_controller
//   Turns the player's debounced fire/reload buttons into the one-hot
//   fire_state sequence Loaded -> Fired (one clk) -> Idle, and tracks the
//   magazine, cooldown and reload timing. Cooldown and reload are timed
//   in slow_clk ticks, where slow_clk is sampled as data in the clk domain.
//
// Ports:
//   clk          system clock (only clock)
//   rst          synchronous active-high reset
//   slow_clk     game-time clock, rising edge = one tick
//   start        game start level, honoured only in INIT
//   fire_btn     debounced fire button (level)
//   reload_btn   debounced reload button (level)
//   fire_state   one-hot: 001 Loaded, 010 Fired, 100 Idle
//   ammo_count   rounds left in the magazine
//   reloading    high while reloading
//   shots_fired  total shots, saturating at 255
module weapon_controller #(
  parameter int AMMO_MAX       = 8,
  parameter int COOLDOWN_TICKS = 2,
  parameter int RELOAD_TICKS   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       start,
  input  logic       fire_btn,
  input  logic       reload_btn,
  output logic [2:0] fire_state,
  output logic [3:0] ammo_count,
  output logic       reloading,
  output logic [7:0] shots_fired
);

  localparam int MAX_TICKS = (COOLDOWN_TICKS > RELOAD_TICKS) ? COOLDOWN_TICKS : RELOAD_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_TICKS);
  localparam logic [CNT_W-1:0] RELOAD_LAST = CNT_W'(RELOAD_TICKS);
  localparam logic [3:0]       AMMO_FULL   = 4'(AMMO_MAX);

  typedef enum logic [2:0] {
    S_INIT,
    S_LOADED,
    S_FIRED,
    S_COOLDOWN,
    S_RELOAD
  } state_t;

  // Registered rising-edge detectors: bit 0 slow_clk, bit 1 fire, bit 2 reload.
  // They run in every state, so a level held across a state change never
  // produces a late edge, and an edge arriving in a busy state is simply lost.
  logic [2:0] raw_in;
  logic [2:0] edge_pulse;

  assign raw_in = {reload_btn, fire_btn, slow_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      logic prev_reg;
      logic edge_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          prev_reg <= 1'b0;
          edge_reg <= 1'b0;
        end else begin
          prev_reg <= raw_in[gi];
          edge_reg <= raw_in[gi] & ~prev_reg;
        end
      end

      assign edge_pulse[gi] = edge_reg;
    end
  endgenerate

  logic tick, fire_edge, reload_edge;
  assign tick        = edge_pulse[0];
  assign fire_edge   = edge_pulse[1];
  assign reload_edge = edge_pulse[2];

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [3:0]       ammo_reg, ammo_next;
  logic [7:0]       shots_reg, shots_next;

  assign cnt_inc = cnt_reg + 1'b1;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_INIT;
      cnt_reg   <= '0;
      ammo_reg  <= 4'd0;
      shots_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ammo_reg  <= ammo_next;
      shots_reg <= shots_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ammo_next  = ammo_reg;
    shots_next = shots_reg;

    unique case (state_reg)
      S_INIT: begin
        if (start) begin
          state_next = S_LOADED;
          ammo_next  = AMMO_FULL;
        end
      end

      S_LOADED: begin
        // Fire has priority over a reload edge on the same cycle.
        if (fire_edge) begin
          state_next = S_FIRED;
          ammo_next  = ammo_reg - 4'd1;
          if (shots_reg != 8'hFF) begin
            shots_next = shots_reg + 8'd1;
          end
        end else if (reload_edge && (ammo_reg < AMMO_FULL)) begin
          state_next = S_RELOAD;
          cnt_next   = '0;
        end
      end

      S_FIRED: begin
        // Any tick seen here is deliberately not counted.
        state_next = S_COOLDOWN;
        cnt_next   = '0;
      end

      S_COOLDOWN: begin
        if (tick) begin
          if (cnt_inc == COOL_LAST) begin
            cnt_next   = '0;
            state_next = (ammo_reg != 4'd0) ? S_LOADED : S_RELOAD;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end

      S_RELOAD: begin
        if (tick) begin
          if (cnt_inc == RELOAD_LAST) begin
            cnt_next   = '0;
            ammo_next  = AMMO_FULL;
            state_next = S_LOADED;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end

      default: begin
        state_next = S_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    fire_state = 3'b100;
    reloading  = 1'b0;
    unique case (state_reg)
      S_LOADED: fire_state = 3'b001;
      S_FIRED:  fire_state = 3'b010;
      S_RELOAD: reloading  = 1'b1;
      default:  fire_state = 3'b100;
    endcase
  end

  assign ammo_count  = ammo_reg;
  assign shots_fired = shots_reg;

endmodule
